// File: rtl/mem_pkg.sv
// Shared memory-port definitions: responder FSM states and the store
// byte-lane enable patterns used by both the core and the data memory.
package mem_pkg;

  typedef enum logic [1:0] {
    s_mem_idle,
    s_mem_busy,
    s_mem_done
  } s_mem;

  // Lane-enable patterns for byte, halfword and word stores.
  localparam logic [3:0] MEM_WE_BYTE = 4'b0001;
  localparam logic [3:0] MEM_WE_HALF = 4'b0011;
  localparam logic [3:0] MEM_WE_WORD = 4'b1111;

  // Width of the latency down-counter; holds values up to 15.
  localparam int MEM_CNT_W = 4;

endpackage

// File: rtl/mem_bram.sv
// Single-port 2**ADDR_W x 32 synchronous RAM with per-byte write enables
// and a registered read. Written so synthesis maps it onto block RAM.
module mem_bram #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              en,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  // Enabled access: write the selected lanes and register the read word.
  // NOTE: no reset on the array or the read register; a reset would stop
  // the tools from mapping this onto block RAM, and the contents are
  // meant to survive a core reset anyway.
  // NOTE: sequential state uses non-blocking assignments so every
  // register samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int k = 0; k < 4; k++) begin
        if (we[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder between the core's data port and block RAM.
// Accepts one request at a time and pulses memory_done LATENCY cycles
// after the request cycle; load data is presented on dout in that cycle.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  input  logic [3:0]  data_we,
  input  logic        load,
  output logic [31:0] dout,
  output logic        memory_done,
  output logic        busy,
  output logic        err
);

  // Reject illegal latency settings while elaborating.
  if (LATENCY < 2 || LATENCY > 15) begin : g_bad_latency
    $error("data_mem_responder: LATENCY must be in 2..15");
  end

  s_mem                 state, next_state;
  logic [MEM_CNT_W-1:0] cnt, next_cnt;

  // Latched request fields.
  logic [ADDR_W-1:0]    req_widx;
  logic [31:0]          req_din;
  logic [3:0]           req_we;
  logic                 req_load;
  logic                 req_oor;

  logic                 strobe;
  logic                 accept;
  logic                 collide;
  logic                 in_range;
  logic                 access;
  logic [31:0]          rdata;
  logic [31:0]          load_data;
  logic [31:0]          dout_q;

  assign strobe   = load || (data_we != 4'b0000);
  assign in_range = (addr >> (ADDR_W + 2)) == 32'd0;
  // The RAM is touched exactly once, in the last BUSY cycle.
  assign access   = (state == s_mem_busy) && (cnt == MEM_CNT_W'(1));

  // Next-state, counter and acceptance decode.
  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    accept     = 1'b0;
    collide    = 1'b0;
    case (state)
      s_mem_idle: begin
        if (strobe) begin
          accept     = 1'b1;
          next_state = s_mem_busy;
          next_cnt   = MEM_CNT_W'(LATENCY - 1);
        end
      end
      s_mem_busy: begin
        collide  = strobe;
        next_cnt = cnt - MEM_CNT_W'(1);
        // Counter reaches zero as the FSM enters DONE.
        if (cnt == MEM_CNT_W'(1)) next_state = s_mem_done;
      end
      s_mem_done: begin
        collide    = strobe;
        next_state = s_mem_idle;
      end
      default: next_state = s_mem_idle;
    endcase
  end

  // FSM state and latency counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= s_mem_idle;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // Capture request fields on acceptance; a load combined with a store
  // is handled as the store, and out-of-range stores write nothing.
  always_ff @(posedge clk) begin
    if (accept) begin
      req_widx <= addr[ADDR_W+1:2];
      req_din  <= din;
      req_we   <= in_range ? data_we : 4'b0000;
      req_load <= load && (data_we == 4'b0000);
      req_oor  <= !in_range;
    end
  end

  // Sticky error: collisions, out-of-range and load+store requests.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err <= 1'b0;
    end else if (collide || (accept && (!in_range || (load && data_we != 4'b0000)))) begin
      err <= 1'b1;
    end
  end

  mem_bram #(.ADDR_W(ADDR_W)) u_bram (
    .clk   (clk),
    .en    (access),
    .we    (access ? req_we : 4'b0000),
    .addr  (req_widx),
    .wdata (req_din),
    .rdata (rdata)
  );

  assign load_data = req_oor ? 32'd0 : rdata;

  // Hold the last completed load's data between loads.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dout_q <= 32'd0;
    end else if (state == s_mem_done && req_load) begin
      dout_q <= load_data;
    end
  end

  // Present fresh load data in the DONE cycle itself, held value otherwise.
  always_comb begin
    dout = dout_q;
    if (state == s_mem_done && req_load) dout = load_data;
  end

  assign memory_done = (state == s_mem_done);
  assign busy        = (state != s_mem_idle);

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a LATENCY=2 instance for the
// main load/store/error sequence and a LATENCY=5 instance for timing.
module tb_data_mem_responder;
  import mem_pkg::*;

  logic        clk;
  logic        rstn;

  logic [31:0] addr2, din2, dout2;
  logic [3:0]  we2;
  logic        load2, done2, busy2, err2;

  logic [31:0] addr5, din5, dout5;
  logic [3:0]  we5;
  logic        load5, done5, busy5, err5;

  int n_checks = 0;
  int n_fail   = 0;

  data_mem_responder #(.ADDR_W(12), .LATENCY(2)) u_dut2 (
    .clk(clk), .rstn(rstn), .addr(addr2), .din(din2), .data_we(we2),
    .load(load2), .dout(dout2), .memory_done(done2), .busy(busy2), .err(err2)
  );

  data_mem_responder #(.ADDR_W(12), .LATENCY(5)) u_dut5 (
    .clk(clk), .rstn(rstn), .addr(addr5), .din(din5), .data_we(we5),
    .load(load5), .dout(dout5), .memory_done(done5), .busy(busy5), .err(err5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set2(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we, input logic ld);
    addr2 = a; din2 = d; we2 = we; load2 = ld;
  endtask

  task automatic set5(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we, input logic ld);
    addr5 = a; din5 = d; we5 = we; load5 = ld;
  endtask

  // Full LATENCY=2 transaction with timing and data checks.
  task automatic op2(input string tag, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] we, input logic ld, input logic [31:0] exp_dout);
    set2(a, d, we, ld);
    step();
    set2(32'd0, 32'd0, 4'd0, 1'b0);
    check({tag, " T+1 done"}, done2, 0);
    check({tag, " T+1 busy"}, busy2, 1);
    step();
    check({tag, " T+2 done"}, done2, 1);
    check({tag, " T+2 dout"}, dout2, exp_dout);
    step();
    check({tag, " T+3 done"}, done2, 0);
    check({tag, " T+3 busy"}, busy2, 0);
  endtask

  initial begin
    rstn = 1'b0;
    set2(32'd0, 32'd0, 4'd0, 1'b0);
    set5(32'd0, 32'd0, 4'd0, 1'b0);
    step();
    step();
    check("reset dout", dout2, 32'd0);
    check("reset done", done2, 0);
    check("reset busy", busy2, 0);
    check("reset err", err2, 0);
    check("reset busy5", busy5, 0);
    rstn = 1'b1;
    step();

    // Word store, then loads with byte and halfword merges.
    op2("st word",   32'h10, 32'hDEADBEEF, MEM_WE_WORD, 1'b0, 32'h0);
    op2("ld word",   32'h10, 32'h0,        4'd0,        1'b1, 32'hDEADBEEF);
    check("err after word", err2, 0);
    op2("st byte",   32'h10, 32'h000000AA, MEM_WE_BYTE, 1'b0, 32'hDEADBEEF);
    op2("ld byte",   32'h10, 32'h0,        4'd0,        1'b1, 32'hDEADBEAA);
    op2("st half",   32'h10, 32'h00001234, MEM_WE_HALF, 1'b0, 32'hDEADBEAA);
    op2("ld half",   32'h10, 32'h0,        4'd0,        1'b1, 32'hDEAD1234);
    op2("st w0",     32'h0,  32'h13579BDF, MEM_WE_WORD, 1'b0, 32'hDEAD1234);
    op2("st unalig", 32'h23, 32'h11223344, MEM_WE_WORD, 1'b0, 32'hDEAD1234);
    op2("ld w8",     32'h20, 32'h0,        4'd0,        1'b1, 32'h11223344);
    op2("st w40",    32'h40, 32'hCAFEF00D, MEM_WE_WORD, 1'b0, 32'h11223344);
    check("err before collide", err2, 0);

    // Second load strobe while busy: ignored, one done, err raised.
    set2(32'h10, 32'h0, 4'd0, 1'b1);
    step();
    set2(32'h40, 32'h0, 4'd0, 1'b1);
    check("coll T+1 done", done2, 0);
    step();
    set2(32'd0, 32'd0, 4'd0, 1'b0);
    check("coll T+2 done", done2, 1);
    check("coll T+2 dout", dout2, 32'hDEAD1234);
    step();
    check("coll T+3 done", done2, 0);
    check("coll T+3 busy", busy2, 0);
    step();
    check("coll T+4 done", done2, 0);
    check("coll T+4 dout", dout2, 32'hDEAD1234);
    check("coll err", err2, 1);

    // Reset while a load is outstanding: dropped, no done.
    set2(32'h10, 32'h0, 4'd0, 1'b1);
    step();
    set2(32'd0, 32'd0, 4'd0, 1'b0);
    rstn = 1'b0;
    #1;
    check("rst busy", busy2, 0);
    check("rst done", done2, 0);
    check("rst dout", dout2, 32'd0);
    check("rst err", err2, 0);
    step();
    check("rst T+2 done", done2, 0);
    rstn = 1'b1;
    step();
    check("rst T+3 done", done2, 0);
    check("rst T+3 busy", busy2, 0);
    op2("ld w0 post rst", 32'h0, 32'h0, 4'd0, 1'b1, 32'h13579BDF);
    check("err post rst", err2, 0);

    // Out-of-range accesses: write suppressed, load returns zero.
    op2("st oor", 32'h4000, 32'h5555AAAA, MEM_WE_WORD, 1'b0, 32'h13579BDF);
    check("oor err", err2, 1);
    op2("ld w0 after oor", 32'h0,    32'h0, 4'd0, 1'b1, 32'h13579BDF);
    op2("ld oor",          32'h4000, 32'h0, 4'd0, 1'b1, 32'h0);

    // LATENCY=5: store, strobe in DONE ignored, strobe after accepted.
    check("l5 err start", err5, 0);
    set5(32'h10, 32'h0BADCAFE, MEM_WE_WORD, 1'b0);
    step();
    set5(32'd0, 32'd0, 4'd0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("l5 T+%0d busy", i), busy5, 1);
      check($sformatf("l5 T+%0d done", i), done5, 0);
      step();
    end
    check("l5 T+5 done", done5, 1);
    check("l5 T+5 busy", busy5, 1);
    set5(32'h10, 32'hFFFFFFFF, MEM_WE_WORD, 1'b0);
    step();
    check("l5 T+6 done", done5, 0);
    check("l5 T+6 busy", busy5, 0);
    check("l5 T+6 err", err5, 1);
    set5(32'h10, 32'h0, 4'd0, 1'b1);
    step();
    set5(32'd0, 32'd0, 4'd0, 1'b0);
    check("l5 T+7 busy", busy5, 1);
    for (int i = 8; i <= 10; i++) begin
      step();
      check($sformatf("l5 T+%0d done", i), done5, 0);
    end
    step();
    check("l5 T+11 done", done5, 1);
    check("l5 T+11 dout", dout5, 32'h0BADCAFE);
    step();
    check("l5 T+12 done", done5, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
